// File: rtl/stopwatch_ctrl_if.sv
// Command/status bundle between a stopwatch front panel (master) and
// stopwatch_ctrl (slave).
interface stopwatch_ctrl_if;
  logic       start;
  logic       stop;
  logic       clear;
  logic       dir;
  logic [7:0] preset;
  logic [7:0] bcd;
  logic       tick;
  logic [1:0] state;
  logic       running;
  logic       done;

  modport master (
    output start, stop, clear, dir, preset,
    input  bcd, tick, state, running, done
  );

  modport slave (
    input  start, stop, clear, dir, preset,
    output bcd, tick, state, running, done
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch / countdown controller: prescaler tick enable, two-digit BCD
// up/down counter and the start/stop/clear sequencing FSM.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 25_000_000,
  parameter int PRE_W    = 25
) (
  input  logic            clk,
  input  logic            reset,
  stopwatch_ctrl_if.slave sw
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ZERO = {PRE_W{1'b0}};
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

  function automatic logic [3:0] clamp_nib(input logic [3:0] n);
    logic [3:0] r;
    if (n > 4'd9) r = 4'd9;
    else          r = n;
    return r;
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] t;
    logic [3:0] u;
    t = v[7:4];
    u = v[3:0];
    if (u >= 4'd9) begin
      u = 4'd0;
      if (t >= 4'd9) t = 4'd0;
      else           t = t + 4'd1;
    end else begin
      u = u + 4'd1;
    end
    return {t, u};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [3:0] t;
    logic [3:0] u;
    t = v[7:4];
    u = v[3:0];
    if (u == 4'd0) begin
      u = 4'd9;
      if (t == 4'd0) t = 4'd9;
      else           t = t - 4'd1;
    end else begin
      u = u - 4'd1;
    end
    return {t, u};
  endfunction

  state_e           state_q,     state_d;
  logic [7:0]       bcd_q,       bcd_d;
  logic             tick_q,      tick_d;
  logic             running_q,   running_d;
  logic             done_q,      done_d;
  logic [PRE_W-1:0] pre_q,       pre_d;
  logic             dir_q,       dir_d;
  logic [7:0]       tgt_q,       tgt_d;
  logic             start_dly_q, start_dly_d;
  logic             stop_dly_q,  stop_dly_d;
  logic             clear_dly_q, clear_dly_d;

  logic       cmd_start_s, cmd_stop_s, cmd_clear_s;
  logic       wrap_s, term_s;
  logic [7:0] cnt_next_s, tgt_new_s;

  // Next-state, counter and prescaler decode.
  always_comb begin
    start_dly_d = sw.start;
    stop_dly_d  = sw.stop;
    clear_dly_d = sw.clear;

    // Coinciding edges resolve clear > stop > start.
    cmd_clear_s = sw.clear & ~clear_dly_q;
    cmd_stop_s  = sw.stop & ~stop_dly_q & ~cmd_clear_s;
    cmd_start_s = sw.start & ~start_dly_q & ~(sw.stop & ~stop_dly_q) & ~cmd_clear_s;

    wrap_s     = (pre_q == PRE_LAST);
    cnt_next_s = dir_q ? bcd_dec(bcd_q) : bcd_inc(bcd_q);
    term_s     = dir_q ? (cnt_next_s == 8'h00)
                       : ((tgt_q != 8'h00) && (cnt_next_s == tgt_q));
    tgt_new_s  = {clamp_nib(sw.preset[7:4]), clamp_nib(sw.preset[3:0])};

    state_d = state_q;
    bcd_d   = bcd_q;
    tick_d  = 1'b0;
    pre_d   = pre_q;
    dir_d   = dir_q;
    tgt_d   = tgt_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (cmd_clear_s) begin
          state_d = ST_IDLE;
          bcd_d   = 8'h00;
          pre_d   = PRE_ZERO;
        end else if (cmd_start_s) begin
          dir_d = sw.dir;
          tgt_d = tgt_new_s;
          pre_d = PRE_ZERO;
          if (!sw.dir) begin
            bcd_d   = 8'h00;
            state_d = ST_RUN;
          end else if (tgt_new_s == 8'h00) begin
            bcd_d   = 8'h00;
            state_d = ST_DONE;
          end else begin
            bcd_d   = tgt_new_s;
            state_d = ST_RUN;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        if (cmd_clear_s) begin
          state_d = ST_IDLE;
          bcd_d   = 8'h00;
          pre_d   = PRE_ZERO;
        end else if (wrap_s) begin
          // A terminal count reaches DONE even if stop lands on the same edge.
          pre_d  = PRE_ZERO;
          tick_d = 1'b1;
          bcd_d  = cnt_next_s;
          if (term_s)          state_d = ST_DONE;
          else if (cmd_stop_s) state_d = ST_PAUSE;
          else                 state_d = ST_RUN;
        end else if (cmd_stop_s) begin
          state_d = ST_PAUSE;
        end else begin
          pre_d = pre_q + PRE_ONE;
        end
      end
      ST_PAUSE: begin
        if (cmd_clear_s) begin
          state_d = ST_IDLE;
          bcd_d   = 8'h00;
          pre_d   = PRE_ZERO;
        end else if (cmd_start_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        bcd_d   = 8'h00;
        pre_d   = PRE_ZERO;
      end
    endcase

    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bcd_q       <= 8'h00;
      tick_q      <= 1'b0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      pre_q       <= PRE_ZERO;
      dir_q       <= 1'b0;
      tgt_q       <= 8'h00;
      start_dly_q <= 1'b0;
      stop_dly_q  <= 1'b0;
      clear_dly_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcd_q       <= bcd_d;
      tick_q      <= tick_d;
      running_q   <= running_d;
      done_q      <= done_d;
      pre_q       <= pre_d;
      dir_q       <= dir_d;
      tgt_q       <= tgt_d;
      start_dly_q <= start_dly_d;
      stop_dly_q  <= stop_dly_d;
      clear_dly_q <= clear_dly_d;
    end
  end

  assign sw.bcd     = bcd_q;
  assign sw.tick    = tick_q;
  assign sw.state   = state_q;
  assign sw.running = running_q;
  assign sw.done    = done_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4: a per-cycle vector
// table plus hand-written multi-cycle sequences.
module tb_stopwatch_ctrl;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_err    = 0;

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(.TICK_DIV(TD), .PRE_W(3)) dut (
    .clk  (clk),
    .reset(reset),
    .sw   (sw_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st, sp, cl, dr;
    logic [7:0] pr;
    logic [7:0] e_bcd;
    logic       e_tick;
    logic [1:0] e_state;
  } vec_t;

  vec_t vecs[39];

  function automatic vec_t mk(input logic st, sp, cl, dr, input logic [7:0] pr,
                              input logic [7:0] eb, input logic et, input logic [1:0] es);
    vec_t v;
    v.st = st; v.sp = sp; v.cl = cl; v.dr = dr; v.pr = pr;
    v.e_bcd = eb; v.e_tick = et; v.e_state = es;
    return v;
  endfunction

  function automatic logic [7:0] to_bcd(input int k);
    return {4'(k / 10), 4'(k % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [7:0] eb, input logic et,
                         input logic [1:0] es);
    chk({name, "_bcd"},     32'(sw_if.bcd),     32'(eb));
    chk({name, "_tick"},    32'(sw_if.tick),    32'(et));
    chk({name, "_state"},   32'(sw_if.state),   32'(es));
    chk({name, "_running"}, 32'(sw_if.running), 32'(es == 2'b01));
    chk({name, "_done"},    32'(sw_if.done),    32'(es == 2'b11));
  endtask

  task automatic step(input logic st, sp, cl, dr, input logic [7:0] pr);
    @(negedge clk);
    sw_if.start = st; sw_if.stop = sp; sw_if.clear = cl;
    sw_if.dir = dr;   sw_if.preset = pr;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(input string name, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (sw_if.tick !== 1'b1 && n < 50);
    if (sw_if.tick !== 1'b1) begin
      n_checks++;
      n_err++;
      $display("FAIL %s_timeout: got no tick within %0d cycles, required a tick", name, n);
    end
  endtask

  initial begin
    int n;
    vecs[0]  = mk(0,0,0,0,8'h00, 8'h00,0,2'b00);
    vecs[1]  = mk(1,0,0,1,8'h03, 8'h03,0,2'b01);
    vecs[2]  = mk(1,0,0,1,8'h03, 8'h03,0,2'b01);
    vecs[3]  = mk(0,0,0,0,8'h00, 8'h03,0,2'b01);
    vecs[4]  = mk(0,0,0,0,8'h00, 8'h03,0,2'b01);
    vecs[5]  = mk(0,0,0,0,8'h00, 8'h02,1,2'b01);
    vecs[6]  = mk(0,0,0,0,8'h00, 8'h02,0,2'b01);
    vecs[7]  = mk(0,0,0,0,8'h00, 8'h02,0,2'b01);
    vecs[8]  = mk(0,0,0,0,8'h00, 8'h02,0,2'b01);
    vecs[9]  = mk(0,0,0,0,8'h00, 8'h01,1,2'b01);
    vecs[10] = mk(0,0,0,0,8'h00, 8'h01,0,2'b01);
    vecs[11] = mk(0,0,0,0,8'h00, 8'h01,0,2'b01);
    vecs[12] = mk(0,0,0,0,8'h00, 8'h01,0,2'b01);
    vecs[13] = mk(0,0,0,0,8'h00, 8'h00,1,2'b11);
    vecs[14] = mk(0,1,0,0,8'h00, 8'h00,0,2'b11);
    vecs[15] = mk(0,0,1,0,8'h00, 8'h00,0,2'b00);
    vecs[16] = mk(1,0,0,1,8'h00, 8'h00,0,2'b11);
    vecs[17] = mk(0,0,0,0,8'h00, 8'h00,0,2'b11);
    vecs[18] = mk(1,0,0,1,8'hAF, 8'h99,0,2'b01);
    vecs[19] = mk(1,1,1,0,8'h00, 8'h00,0,2'b00);
    vecs[20] = mk(0,0,0,0,8'h00, 8'h00,0,2'b00);
    vecs[21] = mk(1,1,0,0,8'h00, 8'h00,0,2'b00);
    vecs[22] = mk(0,0,0,0,8'h00, 8'h00,0,2'b00);
    vecs[23] = mk(1,0,0,0,8'h00, 8'h00,0,2'b01);
    vecs[24] = mk(0,0,0,0,8'h00, 8'h00,0,2'b01);
    vecs[25] = mk(0,0,0,0,8'h00, 8'h00,0,2'b01);
    vecs[26] = mk(0,0,0,0,8'h00, 8'h00,0,2'b01);
    vecs[27] = mk(0,1,0,0,8'h00, 8'h01,1,2'b10);
    vecs[28] = mk(0,0,0,0,8'h00, 8'h01,0,2'b10);
    vecs[29] = mk(1,0,0,0,8'h00, 8'h01,0,2'b01);
    vecs[30] = mk(0,0,0,0,8'h00, 8'h01,0,2'b01);
    vecs[31] = mk(0,0,0,0,8'h00, 8'h01,0,2'b01);
    vecs[32] = mk(0,0,0,0,8'h00, 8'h01,0,2'b01);
    vecs[33] = mk(0,0,0,0,8'h00, 8'h02,1,2'b01);
    vecs[34] = mk(0,0,0,0,8'h00, 8'h02,0,2'b01);
    vecs[35] = mk(0,0,0,0,8'h00, 8'h02,0,2'b01);
    vecs[36] = mk(0,0,0,0,8'h00, 8'h02,0,2'b01);
    vecs[37] = mk(0,0,1,0,8'h00, 8'h00,0,2'b00);
    vecs[38] = mk(0,0,0,0,8'h00, 8'h00,0,2'b00);

    reset = 1'b1;
    sw_if.start = 1'b0; sw_if.stop = 1'b0; sw_if.clear = 1'b0;
    sw_if.dir = 1'b0;   sw_if.preset = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 8'h00, 1'b0, 2'b00);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 39; i++) begin
      step(vecs[i].st, vecs[i].sp, vecs[i].cl, vecs[i].dr, vecs[i].pr);
      chk_all($sformatf("vec%0d", i), vecs[i].e_bcd, vecs[i].e_tick, vecs[i].e_state);
    end

    // Free-running up count from 00 through 99 back to 00.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("up_running", 32'(sw_if.running), 32'd1);
    sw_if.start = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      wait_tick("up", n);
      chk($sformatf("up_interval%0d", k), 32'(n), 32'(TD));
      chk($sformatf("up_bcd%0d", k), 32'(sw_if.bcd), 32'(to_bcd(k % 100)));
      chk($sformatf("up_done%0d", k), 32'(sw_if.done), 32'd0);
    end

    // Up to target 12, hold, then clear.
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    chk_all("tgt_clr0", 8'h00, 1'b0, 2'b00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h12);
    sw_if.start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      wait_tick("tgt", n);
      chk($sformatf("tgt_bcd%0d", k), 32'(sw_if.bcd), 32'(to_bcd(k)));
      chk($sformatf("tgt_done%0d", k), 32'(sw_if.done), 32'(k == 12));
    end
    repeat (8) begin
      @(posedge clk);
      #1;
      chk_all("tgt_hold", 8'h12, 1'b0, 2'b11);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    chk_all("tgt_clear", 8'h00, 1'b0, 2'b00);
    sw_if.clear = 1'b0;

    // Pause two cycles after a tick, stay frozen, resume mid-period.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    sw_if.start = 1'b0;
    wait_tick("pause_first", n);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    sw_if.stop = 1'b1;
    @(posedge clk);
    #1;
    sw_if.stop = 1'b0;
    chk_all("pause_enter", 8'h01, 1'b0, 2'b10);
    repeat (20) begin
      @(posedge clk);
      #1;
      chk_all("pause_frozen", 8'h01, 1'b0, 2'b10);
    end
    sw_if.start = 1'b1;
    @(posedge clk);
    #1;
    sw_if.start = 1'b0;
    chk_all("resume", 8'h01, 1'b0, 2'b01);
    wait_tick("resume", n);
    chk("resume_interval", 32'(n), 32'd2);
    chk("resume_bcd", 32'(sw_if.bcd), 32'h02);

    // Start held high through reset release.
    reset = 1'b1;
    sw_if.start = 1'b1;
    #1;
    chk_all("hold_reset", 8'h00, 1'b0, 2'b00);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_all("start_thru_reset", 8'h00, 1'b0, 2'b01);
    sw_if.start = 1'b0;

    // Asynchronous reset between edges while running.
    wait_tick("async", n);
    chk("async_pre_bcd", 32'(sw_if.bcd), 32'h01);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_all("async_reset", 8'h00, 1'b0, 2'b00);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_all("after_reset", 8'h00, 1'b0, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
